// File: rtl/id_stage.sv
// Instruction-decode stage: 32x32 register file with write-through bypass, operand
// decode into the ID/EX latch, load-use hazard detection and sticky HALT tracking.
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IR_if,
    input  logic [31:0] NPC_if,
    input  logic        valid_if,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [31:0] Imm,
    output logic [31:0] NPC_id,
    output logic [31:0] IR_id,
    output logic        valid_id,
    output logic        hazard,
    output logic        halted
);

    localparam logic [5:0] OP_LW    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101001;
    localparam logic [5:0] OP_BEQZ  = 6'b110100;
    localparam logic [5:0] OP_BNEQZ = 6'b110101;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // Fetch-side instruction fields
    logic [5:0]  op_if;
    logic [4:0]  rs_if;
    logic [4:0]  rt_if;
    logic [15:0] imm_if;

    assign op_if  = IR_if[31:26];
    assign rs_if  = IR_if[25:21];
    assign rt_if  = IR_if[20:16];
    assign imm_if = IR_if[15:0];

    // Register file: flops rather than block RAM because reset must clear every entry
    logic [31:0] rf_q [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    logic        wb_live;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    assign wb_live = wb_en && (wb_addr != 5'd0);

    always_comb begin
        rs_val = rf_q[rs_if];
        rt_val = rf_q[rt_if];
        if (rs_if == 5'd0) begin
            rs_val = '0;
        end else if (wb_live && (wb_addr == rs_if)) begin
            rs_val = wb_data;
        end
        if (rt_if == 5'd0) begin
            rt_val = '0;
        end else if (wb_live && (wb_addr == rt_if)) begin
            rt_val = wb_data;
        end
    end

    // ID/EX latch
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] ir_q, ir_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        npc_d    = npc_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        if (flush || (!stall && (halted_q || !valid_if))) begin
            a_d     = '0;
            b_d     = '0;
            imm_d   = '0;
            npc_d   = '0;
            ir_d    = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            a_d     = rs_val;
            b_d     = rt_val;
            imm_d   = {{16{imm_if[15]}}, imm_if};
            npc_d   = NPC_if;
            ir_d    = IR_if;
            valid_d = 1'b1;
            if (op_if == OP_HALT) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            npc_q    <= '0;
            ir_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            npc_q    <= npc_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Load-use hazard: a consumer in fetch reads the register the latched LW is loading.
    // rt is only a source for register-register ALU ops, stores and branches.
    logic [4:0] rt_id;
    logic       id_is_lw;
    logic       if_rt_src;

    assign rt_id     = ir_q[20:16];
    assign id_is_lw  = (ir_q[31:26] == OP_LW);
    assign if_rt_src = (op_if[5:4] == 2'b00) || (op_if == OP_SW) ||
                       (op_if == OP_BEQZ) || (op_if == OP_BNEQZ);

    always_comb begin
        hazard = 1'b0;
        if (valid_q && id_is_lw && (rt_id != 5'd0) && valid_if) begin
            hazard = (rs_if == rt_id) || (if_rt_src && (rt_if == rt_id));
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign Imm      = imm_q;
    assign NPC_id   = npc_q;
    assign IR_id    = ir_q;
    assign valid_id = valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: expected latch contents are queued when stimulus
// is driven and compared after the capturing edge.
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] IR_if;
    logic [31:0] NPC_if;
    logic        valid_if;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Imm;
    logic [31:0] NPC_id;
    logic [31:0] IR_id;
    logic        valid_id;
    logic        hazard;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [161:0] sb_q [$];
    logic [161:0] exp_v;
    logic [161:0] obs;

    assign obs = {A, B, Imm, NPC_id, IR_id, valid_id, halted};

    id_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .IR_if    (IR_if),
        .NPC_if   (NPC_if),
        .valid_if (valid_if),
        .stall    (stall),
        .flush    (flush),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .A        (A),
        .B        (B),
        .Imm      (Imm),
        .NPC_id   (NPC_id),
        .IR_id    (IR_id),
        .valid_id (valid_id),
        .hazard   (hazard),
        .halted   (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [161:0] pack(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] imm, input logic [31:0] npc,
                                          input logic [31:0] ir, input logic v, input logic h);
        return {a, b, imm, npc, ir, v, h};
    endfunction

    task automatic drv(input logic [31:0] ir, input logic [31:0] npc, input logic v,
                       input logic st, input logic fl, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
        IR_if    = ir;
        NPC_if   = npc;
        valid_if = v;
        stall    = st;
        flush    = fl;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drv(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (obs !== 162'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, 162'd0);
        end
        n_checks++;
        if (hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hazard got=%b exp=0", hazard);
        end
        tick();
        rst_n = 1'b1;
        $display("reset released, outputs checked");
    endtask

    task automatic test_write_read();
        logic [31:0] ir;
        drv(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_00AA);
        sb_q.push_back(pack(0, 0, 0, 0, 0, 1'b0, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL wr_bubble got=%h exp=%h", obs, exp_v);
        end
        ir = 32'h00A0_0800;
        drv(ir, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(32'hAA, 0, 32'h800, 32'h104, ir, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rd_r5 got=%h exp=%h", obs, exp_v);
        end
        $display("write r5 then ADD r1,r5,r0: A=%h B=%h valid=%b", A, B, valid_id);
    endtask

    task automatic test_bypass();
        logic [31:0] ir;
        ir = mk(6'b000001, 5'd7, 5'd5, 16'h0010);
        drv(ir, 32'h108, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234);
        sb_q.push_back(pack(32'h1234, 32'hAA, 32'h10, 32'h108, ir, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bypass got=%h exp=%h", obs, exp_v);
        end
        ir = mk(6'b000000, 5'd0, 5'd0, 16'h0000);
        drv(ir, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        sb_q.push_back(pack(0, 0, 0, 32'h10C, ir, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL r0_write_same_cycle got=%h exp=%h", obs, exp_v);
        end
        drv(ir, 32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(0, 0, 0, 32'h110, ir, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL r0_read got=%h exp=%h", obs, exp_v);
        end
        ir = mk(6'b000010, 5'd7, 5'd7, 16'h0000);
        drv(ir, 32'h114, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(32'h1234, 32'h1234, 0, 32'h114, ir, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL r7_array got=%h exp=%h", obs, exp_v);
        end
        $display("bypass/r0: last A=%h B=%h", A, B);
    endtask

    task automatic test_imm();
        logic [31:0] ir;
        ir = mk(6'b010000, 5'd5, 5'd0, 16'h8001);
        drv(ir, 32'h118, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(32'hAA, 0, 32'hFFFF_8001, 32'h118, ir, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL imm_neg got=%h exp=%h", obs, exp_v);
        end
        ir = mk(6'b010001, 5'd0, 5'd5, 16'h7FFF);
        drv(ir, 32'h11C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(0, 32'hAA, 32'h0000_7FFF, 32'h11C, ir, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL imm_pos got=%h exp=%h", obs, exp_v);
        end
        $display("immediate: last Imm=%h", Imm);
    endtask

    task automatic test_load_use();
        logic [31:0] lw;
        logic [31:0] cons;
        lw = mk(6'b101000, 5'd5, 5'd3, 16'h0004);
        drv(lw, 32'h120, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(32'hAA, 0, 32'h4, 32'h120, lw, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL lw_latch got=%h exp=%h", obs, exp_v);
        end
        cons = mk(6'b000000, 5'd3, 5'd0, 16'h0000);
        drv(cons, 32'h124, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL hz_rs got=%b exp=1", hazard);
        end
        stall = 1'b1;
        sb_q.push_back(pack(32'hAA, 0, 32'h4, 32'h120, lw, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL stall_hold_lw got=%h exp=%h", obs, exp_v);
        end
        stall = 1'b0;
        sb_q.push_back(pack(0, 0, 0, 32'h124, cons, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL consumer_latch got=%h exp=%h", obs, exp_v);
        end
        n_checks++;
        if (hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL hz_clear got=%b exp=0", hazard);
        end
        lw = mk(6'b101000, 5'd3, 5'd0, 16'h0000);
        drv(lw, 32'h128, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(0, 0, 0, 32'h128, lw, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL lw_rt0_latch got=%h exp=%h", obs, exp_v);
        end
        cons = mk(6'b000000, 5'd0, 5'd0, 16'h0000);
        drv(cons, 32'h12C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL hz_rt0 got=%b exp=0", hazard);
        end
        lw = mk(6'b101000, 5'd0, 5'd3, 16'h0000);
        drv(lw, 32'h130, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(0, 0, 0, 32'h130, lw, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL lw_r3_latch got=%h exp=%h", obs, exp_v);
        end
        drv(mk(6'b010000, 5'd4, 5'd3, 16'h0000), 32'h134, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL hz_rimm_rt got=%b exp=0", hazard);
        end
        drv(mk(6'b101001, 5'd4, 5'd3, 16'h0000), 32'h134, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL hz_sw_rt got=%b exp=1", hazard);
        end
        valid_if = 1'b0;
        #1;
        n_checks++;
        if (hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL hz_invalid_if got=%b exp=0", hazard);
        end
        sb_q.push_back(pack(0, 0, 0, 0, 0, 1'b0, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL invalid_bubble got=%h exp=%h", obs, exp_v);
        end
        $display("load-use checks done, hazard=%b", hazard);
    endtask

    task automatic test_flush_stall();
        logic [31:0] x;
        logic [31:0] z;
        x = mk(6'b000011, 5'd5, 5'd7, 16'h0042);
        drv(x, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(32'hAA, 32'h1234, 32'h42, 32'h200, x, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL fs_load got=%h exp=%h", obs, exp_v);
        end
        drv(mk(6'b000100, 5'd7, 5'd5, 16'h0), 32'h204, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(0, 0, 0, 0, 0, 1'b0, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL flush_and_stall got=%h exp=%h", obs, exp_v);
        end
        z = mk(6'b010010, 5'd7, 5'd0, 16'hFFF0);
        drv(z, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(32'h1234, 0, 32'hFFFF_FFF0, 32'h208, z, 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL fs_load_z got=%h exp=%h", obs, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            drv(mk(6'b000101, 5'd5, 5'd5, 16'(i)), 32'h20C + 32'(4 * i), 1'b1, 1'b1, 1'b0,
                1'b0, 5'd0, 32'h0);
            sb_q.push_back(pack(32'h1234, 0, 32'hFFFF_FFF0, 32'h208, z, 1'b1, 1'b0));
            tick();
            exp_v = sb_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stall_hold_%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
        drv(z, 32'h218, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(0, 0, 0, 0, 0, 1'b0, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL flush_only got=%h exp=%h", obs, exp_v);
        end
        $display("flush/stall priority checks done, IR_id=%h", IR_id);
    endtask

    task automatic test_halt();
        logic [31:0] h;
        h = 32'hFC00_0000;
        drv(h, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(0, 0, 0, 0, 0, 1'b0, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL halt_flushed got=%h exp=%h", obs, exp_v);
        end
        drv(h, 32'h304, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(0, 0, 0, 32'h304, h, 1'b1, 1'b1));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL halt_latch got=%h exp=%h", obs, exp_v);
        end
        for (int i = 0; i < 2; i++) begin
            drv(mk(6'b000000, 5'd5, 5'd7, 16'h1), 32'h308 + 32'(4 * i), 1'b1, 1'b0, 1'b0,
                1'b1, 5'd9, 32'h55);
            sb_q.push_back(pack(0, 0, 0, 0, 0, 1'b0, 1'b1));
            tick();
            exp_v = sb_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL halt_bubble_%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
        wb_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ((obs !== 162'd0) || (hazard !== 1'b0)) begin
            n_fail++;
            $display("FAIL async_reset got=%h hz=%b exp=%h hz=0", obs, hazard, 162'd0);
        end
        #1;
        rst_n = 1'b1;
        drv(mk(6'b000000, 5'd5, 5'd7, 16'h0), 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        sb_q.push_back(pack(0, 0, 0, 32'h400, mk(6'b000000, 5'd5, 5'd7, 16'h0), 1'b1, 1'b0));
        tick();
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rf_cleared_by_reset got=%h exp=%h", obs, exp_v);
        end
        $display("halt/reset checks done, halted=%b", halted);
    endtask

    initial begin
        rst_n = 1'b0;
        drv(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        test_reset();
        test_write_read();
        test_bypass();
        test_imm();
        test_load_use();
        test_flush_stall();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage MIPS32-style pipeline. It sits between fetch and execute. It holds the 32x32 general register file and decodes the fetched instruction. Each cycle it registers the operands (A, B, sign-extended Imm), NPC and IR into the ID/EX latch feeding the execute stage, and it flags load-use hazards and HALT.

## Interface
- No parameters; data width is 32 and register count is 32, both fixed.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- IR_if  in  32  instruction from fetch
- NPC_if  in  32  PC+4 from fetch
- valid_if  in  1  IR_if/NPC_if carry a real instruction
- stall  in  1  hold ID/EX latch contents
- flush  in  1  replace next latched instruction with a bubble (branch taken in EX)
- wb_en  in  1  register-file write enable from writeback
- wb_addr  in  5  write register index
- wb_data  in  32  write data
- A  out  32  rs operand
- B  out  32  rt operand
- Imm  out  32  sign-extended IR[15:0]
- NPC_id  out  32  latched NPC
- IR_id  out  32  latched instruction
- valid_id  out  1  latched slot is a real instruction
- hazard  out  1  combinational load-use hazard request to fetch/hazard control
- halted  out  1  sticky, HALT has been latched

## Operation
- Fields: opcode IR[31:26], rs IR[25:21], rt IR[20:16], imm IR[15:0].
- Opcodes:
  - ALU RR: 00xxxx.
  - ALU RImm: 01xxxx.
  - LW: 101000.
  - SW: 101001.
  - BEQZ: 110100.
  - BNEQZ: 110101.
  - HALT: 111111.
- Register file:
  - r0 reads 0 and writes to r0 are ignored.
  - A write occurs at the clock edge when wb_en=1, independent of stall, flush and halted.
- Write-through bypass: if wb_en=1, wb_addr!=0 and wb_addr equals rs (or rt), the value latched into A (or B) is wb_data, not the stale array value.
- Imm = {{16{IR_if[15]}}, IR_if[15:0]}. It is computed for every opcode.
- Bubble: IR_id=32'h0000_0000 (ADD r0,r0,r0), A=B=Imm=NPC_id=0, valid_id=0.
- Latch update priority, evaluated at each edge:
  1. flush=1: load a bubble (flush beats stall).
  2. stall=1: hold all latch outputs unchanged.
  3. halted=1, or valid_if=0: load a bubble.
  4. Otherwise: load the decoded IR_if/NPC_if with valid_id=1.
- Halt: when a HALT instruction is latched under rule 4, halted goes to 1 at the same edge.
  - halted stays 1 until reset.
  - The HALT itself occupies IR_id with valid_id=1.
  - A flush at that edge suppresses both the latch and halted.
- Load-use hazard is combinational. hazard=1 when all of the following hold:
  - valid_id=1;
  - IR_id opcode is LW;
  - IR_id rt != 0;
  - valid_if=1 and IR_if rs == IR_id rt, or IR_if is ALU RR, SW or branch and IR_if rt == IR_id rt.
- The external hazard unit converts hazard into stall. This block never stalls itself.
- During a stall, held A/B are not refreshed by writeback. Control must not stall across a writeback to a held source register.

## Timing
- Latency is 1 cycle: the IR_if sampled at edge N appears on IR_id/A/B/Imm/NPC_id after edge N.
- Register-file read is combinational. The bypass makes a same-cycle write visible at the following edge.
- Reset (rst_n=0, asynchronous):
  - all outputs: bubble values; valid_id=0, halted=0, hazard=0;
  - all 32 registers cleared to 0.
- Reset mid-stall or mid-halt clears everything immediately, without waiting for an edge.
- Release of rst_n is synchronous to the next rising edge.
- Simultaneous cases:
  - flush and stall together: bubble.
  - wb_en to the same register that is being read: bypass value.
  - wb_en with wb_addr=0: no effect.

## Test plan
- Reset then write: write r5=32'h0000_00AA via wb. Next, decode ADD r1,r5,r0 (IR 32'h00A0_0800). Required: A=32'hAA, B=0, valid_id=1 after one edge.
- Bypass and r0: in the same cycle, drive wb_en/r7=32'h1234 and IR_if SUB reading rs=r7. Required: A=32'h1234. A write to r0 of 32'hFFFF_FFFF followed by a read of r0 gives 0.
- Immediate: IR_if RImm with imm=16'h8001. Required: Imm=32'hFFFF_8001. With imm=16'h7FFF, Imm=32'h0000_7FFF.
- Load-use: latch LW rt=r3, then present ADD rs=r3. Required:
  - hazard=1, and asserting stall holds IR_id.
  - rt=r0 on the LW gives hazard=0.
  - An RImm consumer whose rt is r3 but rs is not r3 gives hazard=0.
- Flush/stall priority: assert stall and flush together with a valid instruction. Required: IR_id=0, valid_id=0. Stall alone for 3 cycles keeps outputs unchanged.
- Halt: latch HALT (32'hFC00_0000). Required:
  - halted=1 and valid_id=1 for the HALT.
  - Subsequent valid instructions latch as bubbles, while wb writes still land.
  - Asserting rst_n=0 mid-cycle clears halted asynchronously.
